// File: rtl/seradd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seradd_pkg
// Description : Shared constants for the serial adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package seradd_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/seradd_if.sv
`default_nettype none
// ============================================================================
// Module      : seradd_if
// Description : Operand/result handshake bundle for the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface seradd_if
  import seradd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;

  modport master (
    output in_valid, a_in, b_in, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

endinterface
`default_nettype wire

// File: rtl/seradd_bit.sv
`default_nettype none
// ============================================================================
// Module      : seradd_bit
// Description : One-bit full adder with a registered carry.
// Revision    : 1.0 - initial release
// ============================================================================
module seradd_bit (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic a,
  input  wire logic b,
  input  wire logic load,
  input  wire logic load_val,
  input  wire logic en,
  output logic      s,
  output logic      carry
);

  logic r_carry;

  assign s     = a ^ b ^ r_carry;
  assign carry = r_carry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_carry <= 1'b0;
    end else if (load) begin
      r_carry <= load_val;
    end else if (en) begin
      r_carry <= (a & b) | (a & r_carry) | (b & r_carry);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seradd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seradd_ctrl
// Description : Handshaked bit-serial adder, LSB first, one bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seradd_ctrl
  import seradd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input wire logic clk,
  input wire logic rst,
  seradd_if.slave  bus
);

  localparam int          CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;

  logic w_accept;
  logic w_shift;
  logic w_s;
  logic w_carry;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_shift  = (r_state == SHIFT);

  seradd_bit u_bit (
    .clk      (clk),
    .rst      (rst),
    .a        (r_a[0]),
    .b        (r_b[0]),
    .load     (w_accept),
    .load_val (bus.c_in),
    .en       (w_shift),
    .s        (w_s),
    .carry    (w_carry)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          // Counter parks at its last value so it never wraps.
          if (r_cnt == C_LAST) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_cout  <= w_carry;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The bit cell's carry is frozen in DONE; r_cout keeps it across the next load.
  assign bus.c_out     = (r_state == DONE) ? w_carry : r_cout;
  assign bus.sum       = r_sum;
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_seradd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seradd_ctrl
// Description : Directed self-checking bench for seradd_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seradd_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seradd_if #(.WIDTH(8)) bus ();

  seradd_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one operand set for a single accept edge (controller must be in IDLE).
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.c_in     = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the negedge after the accept edge until out_valid (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.c_in      = 1'b0;
    #12;
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.sum !== 8'h00)      begin errors++; $display("FAIL reset_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.c_out !== 1'b0)     begin errors++; $display("FAIL reset_c_out: got %b expected 0", bus.c_out); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int cyc;
    bus.out_ready = 1'b1;
    start_op(8'h5A, 8'h3C, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_shift: got %b expected 0", bus.in_ready); end
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h96) begin errors++; $display("FAIL basic_sum: got %h expected 96", bus.sum); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL basic_c_out: got %b expected 0", bus.c_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    checks++; if (bus.sum !== 8'h96 || bus.c_out !== 1'b0) begin
      errors++; $display("FAIL basic_hold_idle: got sum=%h c_out=%b expected 96/0", bus.sum, bus.c_out);
    end
  endtask

  task automatic test_carry();
    int cyc;
    start_op(8'hFF, 8'h01, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL carry1_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h00) begin errors++; $display("FAIL carry1_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.c_out !== 1'b1) begin errors++; $display("FAIL carry1_c_out: got %b expected 1", bus.c_out); end
    @(negedge clk);
    checks++; if (bus.c_out !== 1'b1) begin errors++; $display("FAIL carry1_c_out_idle: got %b expected 1", bus.c_out); end
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL carry2_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'hFF) begin errors++; $display("FAIL carry2_sum: got %h expected FF", bus.sum); end
    checks++; if (bus.c_out !== 1'b1) begin errors++; $display("FAIL carry2_c_out: got %b expected 1", bus.c_out); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int cyc;
    bus.out_ready = 1'b0;
    start_op(8'h12, 8'h34, 1'b1);
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.sum !== 8'h47) begin errors++; $display("FAIL bp_sum[%0d]: got %h expected 47", i, bus.sum); end
      checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL bp_c_out[%0d]: got %b expected 0", i, bus.c_out); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_busy_inputs();
    int cyc;
    start_op(8'h10, 8'h20, 1'b0);
    bus.in_valid = 1'b1;
    bus.a_in     = 8'hAA;
    bus.b_in     = 8'h55;
    bus.c_in     = 1'b1;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) bus.a_in = 8'hFF;
      if (cyc == 5) bus.in_valid = 1'b0;
    end
    checks++; if (cyc != 8) begin errors++; $display("FAIL busy_in_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h30) begin errors++; $display("FAIL busy_in_sum: got %h expected 30", bus.sum); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL busy_in_c_out: got %b expected 0", bus.c_out); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL busy_in_no_second: got in_ready=%b busy=%b expected 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_op(8'hAB, 8'hCD, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.sum !== 8'h00)      begin errors++; $display("FAIL rmid_sum: got %h expected 00", bus.sum); end
    checks++; if (bus.c_out !== 1'b0)     begin errors++; $display("FAIL rmid_c_out: got %b expected 0", bus.c_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_no_result: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    start_op(8'h01, 8'h01, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL rmid_fresh_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h02) begin errors++; $display("FAIL rmid_fresh_sum: got %h expected 02", bus.sum); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL rmid_fresh_c_out: got %b expected 0", bus.c_out); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.a_in     = 8'h0F;
    bus.b_in     = 8'h01;
    bus.c_in     = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.a_in = 8'h80;
    bus.b_in = 8'h80;
    bus.c_in = 1'b1;
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h10) begin errors++; $display("FAIL b2b_first_sum: got %h expected 10", bus.sum); end
    checks++; if (bus.c_out !== 1'b0) begin errors++; $display("FAIL b2b_first_c_out: got %b expected 0", bus.c_out); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: got in_ready=%b busy=%b expected 1/0", bus.in_ready, bus.busy);
    end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: got busy=%b expected 1", bus.busy); end
    bus.in_valid = 1'b0;
    wait_done(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 8", cyc); end
    checks++; if (bus.sum !== 8'h01) begin errors++; $display("FAIL b2b_second_sum: got %h expected 01", bus.sum); end
    checks++; if (bus.c_out !== 1'b1) begin errors++; $display("FAIL b2b_second_c_out: got %b expected 1", bus.c_out); end
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_end_idle: got %b expected 1", bus.in_ready); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_busy_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
